// File: rtl/status_value_pkg.sv
// Shared definitions for the status_value drain path: FSM states and skid-buffer sizing.
package status_value_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef logic [1:0] count_t;

   localparam count_t SKID_DEPTH = 2'd2;

endpackage

// File: rtl/status_value_skid.sv
// Two-entry in-order buffer with push, pop and clear; head and occupancy come straight from flops.
module status_value_skid
   import status_value_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_value,
   input  logic             pop,
   input  logic             clear,
   output logic [WIDTH-1:0] head,
   output count_t           count
);

   logic [WIDTH-1:0] slot0;
   logic [WIDTH-1:0] slot1;
   count_t           cnt;
   logic             push_ok;
   logic             pop_ok;

   // A pop frees a slot in the same cycle, so a push into a full buffer is legal only alongside it.
   assign pop_ok  = pop && (cnt != 2'd0);
   assign push_ok = push && ((cnt < SKID_DEPTH) || pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data slots are reset as well, so the head reads zero straight out of reset.
         slot0 <= '0;
         slot1 <= '0;
         cnt   <= 2'd0;
      end else if (clear) begin
         cnt <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (cnt == 2'd0) slot0 <= push_value;
               else             slot1 <= push_value;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               cnt   <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  slot0 <= push_value;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_value;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = slot0;
   assign count = cnt;

endmodule

// File: rtl/status_value_drain.sv
// Drains status_value_vector into a registered valid/ready stream via a 2-entry skid buffer,
// with a flush mode that discards queued entries and a saturating delivered-entry counter.
module status_value_drain
   import status_value_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic [WIDTH-1:0]     sv_value_i,
   input  logic                 sv_valid_i,
   output logic                 sv_pull_o,
   output logic [WIDTH-1:0]     m_value_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   input  logic                 flush_i,
   output logic                 flush_busy_o,
   output logic                 flush_done_o,
   output logic [CNT_WIDTH-1:0] pop_count_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t state;
   state_t state_nxt;
   count_t buf_count;
   logic   push;
   logic   clear;
   logic   handshake;

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) state <= ST_RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      sv_pull_o = 1'b0;
      push      = 1'b0;
      clear     = 1'b0;
      case (state)
         ST_RUN: begin
            // Pull depends only on the vector and occupancy, never on m_ready_i.
            sv_pull_o = sv_valid_i && (buf_count < SKID_DEPTH);
            if (flush_i) begin
               clear     = 1'b1;
               state_nxt = ST_FLUSH;
            end else begin
               push = sv_pull_o;
            end
         end
         ST_FLUSH: begin
            sv_pull_o = sv_valid_i;
            if (!sv_valid_i) state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   status_value_skid #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk        (clk_i),
      .rst_n      (rsn_i),
      .push       (push),
      .push_value (sv_value_i),
      .pop        (handshake),
      .clear      (clear),
      .head       (m_value_o),
      .count      (buf_count)
   );

   assign m_valid_o    = (buf_count != 2'd0);
   assign handshake    = m_valid_o && m_ready_i;
   assign flush_busy_o = (state == ST_FLUSH);
   assign flush_done_o = (state == ST_DONE);

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         pop_count_o <= '0;
      end else if (handshake && (pop_count_o != CNT_MAX)) begin
         pop_count_o <= pop_count_o + CNT_WIDTH'(1);
      end
   end

endmodule
